// File: rtl/ahb_slave_sram.sv
// AHB-Lite slave backed by a word-organised SRAM with byte/halfword/word lanes and
// a fixed number of wait states per data phase.
// Optional feature: define AHB_SLV_ERR_RESP_EN to answer illegal transfers with a
// two-cycle ERROR response; without it illegal transfers complete OKAY with no access.
`timescale 1ns/1ps
module ahb_slave_sram #(
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned ADDR_WIDTH  = 32,
  parameter int unsigned DEPTH       = 256,
  parameter int unsigned WAIT_STATES = 0
) (
  input  logic                  i_clk_ahb,
  input  logic                  i_rst_ahb,
  input  logic                  i_hsel,
  input  logic [ADDR_WIDTH-1:0] i_haddr,
  input  logic                  i_hwrite,
  input  logic [1:0]            i_htrans,
  input  logic [2:0]            i_hsize,
  input  logic [DATA_WIDTH-1:0] i_hwdata,
  input  logic                  i_hready,
  output logic                  o_hreadyout,
  output logic                  o_hresp,
  output logic [DATA_WIDTH-1:0] o_hrdata
);

  localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned AQ_W  = IDX_W + 2;
  localparam int unsigned CNT_W = 4;
  localparam int unsigned LANES = DATA_WIDTH / 8;
  localparam logic [ADDR_WIDTH-1:0] BYTE_LIMIT = ADDR_WIDTH'(DEPTH * 4);

`ifdef AHB_SLV_ERR_RESP_EN
  typedef enum logic [2:0] {ST_IDLE, ST_WAIT, ST_DATA, ST_ERR1, ST_ERR2} state_e;
`else
  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_DATA} state_e;
`endif

  state_e                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [AQ_W-1:0]        addr_q, addr_d;
  logic                   write_q, write_d;
  logic [2:0]             size_q, size_d;
  logic                   legal_q, legal_d;
  logic                   hreadyout_q, hreadyout_d;
  logic                   hresp_q, hresp_d;
  logic [DATA_WIDTH-1:0]  hrdata_q, hrdata_d;

  logic [DATA_WIDTH-1:0]  mem_q [DEPTH];

  logic                   accept_c;
  logic                   legal_c;
  logic                   wr_en_c;
  logic [LANES-1:0]       wmask_c;
  logic [IDX_W-1:0]       wr_idx_c;
  logic [IDX_W-1:0]       rd_idx_c;
  logic [DATA_WIDTH-1:0]  rd_word_c;
  logic                   unused_htrans0_c;

  // Byte-lane enables for a little-endian access of the given size
  function automatic logic [3:0] lane_mask(input logic [1:0] a, input logic [2:0] sz);
    case (sz)
      3'b000:  lane_mask = 4'b0001 << a;
      3'b001:  lane_mask = a[1] ? 4'b1100 : 4'b0011;
      3'b010:  lane_mask = 4'b1111;
      default: lane_mask = 4'b0000;
    endcase
  endfunction

  assign accept_c         = i_hsel & i_htrans[1] & i_hready;
  assign unused_htrans0_c = i_htrans[0];
  assign wr_en_c          = (state_q == ST_DATA) & write_q & legal_q & ~i_rst_ahb;
  assign wmask_c          = lane_mask(addr_q[1:0], size_q);
  assign wr_idx_c         = addr_q[AQ_W-1:2];
  assign rd_idx_c         = addr_d[AQ_W-1:2];

  // Legality of the transfer presented in the current address phase
  always_comb begin
    legal_c = 1'b1;
    if (i_haddr >= BYTE_LIMIT)                  legal_c = 1'b0;
    if (i_hsize > 3'b010)                       legal_c = 1'b0;
    if (i_hsize == 3'b001 && i_haddr[0])        legal_c = 1'b0;
    if (i_hsize == 3'b010 && i_haddr[1:0] != 2'b00) legal_c = 1'b0;
  end

  // Next-state and address-phase capture
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    write_d = write_q;
    size_d  = size_q;
    legal_d = legal_q;
    case (state_q)
      ST_WAIT: begin
        if (cnt_q == '0) state_d = ST_DATA;
        else             cnt_d   = cnt_q - CNT_W'(1);
      end
`ifdef AHB_SLV_ERR_RESP_EN
      ST_ERR1: state_d = ST_ERR2;
`endif
      default: begin
        // IDLE, DATA and ERR2 all end with hreadyout high, so a new transfer may start
        state_d = ST_IDLE;
        if (accept_c) begin
          addr_d  = i_haddr[AQ_W-1:0];
          write_d = i_hwrite;
          size_d  = i_hsize;
          legal_d = legal_c;
`ifdef AHB_SLV_ERR_RESP_EN
          if (!legal_c) begin
            state_d = ST_ERR1;
          end else
`endif
          if (WAIT_STATES > 0) begin
            state_d = ST_WAIT;
            cnt_d   = CNT_W'(WAIT_STATES - 1);
          end else begin
            state_d = ST_DATA;
          end
        end
      end
    endcase
  end

  // Read word for the next data phase, forwarding lanes being written this cycle
  always_comb begin
    rd_word_c = mem_q[rd_idx_c];
    if (wr_en_c && (wr_idx_c == rd_idx_c)) begin
      for (int b = 0; b < int'(LANES); b++) begin
        if (wmask_c[b]) rd_word_c[b*8 +: 8] = i_hwdata[b*8 +: 8];
      end
    end
  end

  // Registered bus responses decoded from the next state
  always_comb begin
    hreadyout_d = 1'b1;
    hresp_d     = 1'b0;
    hrdata_d    = '0;
    case (state_d)
      ST_WAIT: hreadyout_d = 1'b0;
      ST_DATA: if (!write_d && legal_d) hrdata_d = rd_word_c;
`ifdef AHB_SLV_ERR_RESP_EN
      ST_ERR1: begin
        hreadyout_d = 1'b0;
        hresp_d     = 1'b1;
      end
      ST_ERR2: hresp_d = 1'b1;
`endif
      default: ;
    endcase
  end

  // State, captured address phase and output registers
  always_ff @(posedge i_clk_ahb) begin
    if (i_rst_ahb) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      addr_q      <= '0;
      write_q     <= 1'b0;
      size_q      <= '0;
      legal_q     <= 1'b0;
      hreadyout_q <= 1'b1;
      hresp_q     <= 1'b0;
      hrdata_q    <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      addr_q      <= addr_d;
      write_q     <= write_d;
      size_q      <= size_d;
      legal_q     <= legal_d;
      hreadyout_q <= hreadyout_d;
      hresp_q     <= hresp_d;
      hrdata_q    <= hrdata_d;
    end
  end

  // SRAM write port: lane-masked commit at the end of a write data phase
  always_ff @(posedge i_clk_ahb) begin
    if (wr_en_c) begin
      for (int b = 0; b < int'(LANES); b++) begin
        if (wmask_c[b]) mem_q[wr_idx_c][b*8 +: 8] <= i_hwdata[b*8 +: 8];
      end
    end
  end

  assign o_hreadyout = hreadyout_q;
  assign o_hresp     = hresp_q;
  assign o_hrdata    = hrdata_q;

endmodule

// File: tb/tb_ahb_slave_sram.sv
// Bench for ahb_slave_sram: two instances (0 and 2 wait states) against a byte-addressed
// reference memory; directed scenarios followed by randomized single transfers.
`timescale 1ns/1ps
module tb_ahb_slave_sram;

  localparam int unsigned DEPTH = 256;
  localparam int unsigned NBYTE = DEPTH * 4;

`ifdef AHB_SLV_ERR_RESP_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst       [2];
  logic        hsel      [2];
  logic [31:0] haddr     [2];
  logic        hwrite    [2];
  logic [1:0]  htrans    [2];
  logic [2:0]  hsize     [2];
  logic [31:0] hwdata    [2];
  logic        hreadyout [2];
  logic        hresp     [2];
  logic [31:0] hrdata    [2];

  logic [7:0]  mref [2][NBYTE];
  int          tests = 0;
  int          fails = 0;

  always #5 clk = ~clk;

  ahb_slave_sram #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .DEPTH(DEPTH), .WAIT_STATES(0)) u_dut0 (
    .i_clk_ahb(clk), .i_rst_ahb(rst[0]), .i_hsel(hsel[0]), .i_haddr(haddr[0]),
    .i_hwrite(hwrite[0]), .i_htrans(htrans[0]), .i_hsize(hsize[0]), .i_hwdata(hwdata[0]),
    .i_hready(hreadyout[0]), .o_hreadyout(hreadyout[0]), .o_hresp(hresp[0]), .o_hrdata(hrdata[0])
  );

  ahb_slave_sram #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .DEPTH(DEPTH), .WAIT_STATES(2)) u_dut2 (
    .i_clk_ahb(clk), .i_rst_ahb(rst[1]), .i_hsel(hsel[1]), .i_haddr(haddr[1]),
    .i_hwrite(hwrite[1]), .i_htrans(htrans[1]), .i_hsize(hsize[1]), .i_hwdata(hwdata[1]),
    .i_hready(hreadyout[1]), .o_hreadyout(hreadyout[1]), .o_hresp(hresp[1]), .o_hrdata(hrdata[1])
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic bit is_legal(input logic [31:0] a, input logic [2:0] sz);
    if (a >= 32'(NBYTE)) return 1'b0;
    if (sz > 3'd2) return 1'b0;
    if (sz == 3'd1 && a[0]) return 1'b0;
    if (sz == 3'd2 && a[1:0] != 2'b00) return 1'b0;
    return 1'b1;
  endfunction

  function automatic logic [31:0] ref_word(input int d, input logic [31:0] a);
    int base;
    base = int'(a) & ~3;
    return {mref[d][base+3], mref[d][base+2], mref[d][base+1], mref[d][base]};
  endfunction

  // Bytes a .. a+2^sz-1 take the data-bus lane matching their own low address bits
  task automatic ref_write(input int d, input logic [31:0] a, input logic [2:0] sz, input logic [31:0] wd);
    int n;
    int ba;
    n = 1 << sz;
    for (int k = 0; k < n; k++) begin
      ba = int'(a) + k;
      mref[d][ba] = wd[8*(ba % 4) +: 8];
    end
  endtask

  task automatic bus_idle(input int d);
    hsel[d] = 1'b0; haddr[d] = '0; hwrite[d] = 1'b0;
    htrans[d] = 2'b00; hsize[d] = 3'b000; hwdata[d] = '0;
  endtask

  // One non-pipelined transfer; returns data/response of the final cycle and wait count
  task automatic xfer(input int d, input logic wr, input logic [31:0] a, input logic [2:0] sz,
                      input logic [31:0] wd, output logic [31:0] rd, output logic resp_first,
                      output logic resp_last, output int waits);
    @(negedge clk);
    hsel[d] = 1'b1; haddr[d] = a; hwrite[d] = wr; hsize[d] = sz; htrans[d] = 2'b10;
    @(negedge clk);
    hsel[d] = 1'b0; htrans[d] = 2'b00; hwdata[d] = wd;
    waits = 0;
    resp_first = hresp[d];
    while (hreadyout[d] !== 1'b1 && waits < 20) begin
      check("stall_rdata_zero", hrdata[d], 32'h0);
      waits++;
      @(negedge clk);
    end
    rd = hrdata[d];
    resp_last = hresp[d];
  endtask

  // Transfer plus comparison against the reference memory
  task automatic do_check(input int d, input logic wr, input logic [31:0] a, input logic [2:0] sz,
                          input logic [31:0] wd, output logic [31:0] rd);
    logic rf, rl;
    int   w;
    bit   lg;
    int   exp_w;
    logic [31:0] exp_rd;
    lg = is_legal(a, sz);
    exp_rd = (!wr && lg) ? ref_word(d, a) : 32'h0;
    if (ERR_EN && !lg) exp_w = 1;
    else               exp_w = (d == 0) ? 0 : 2;
    xfer(d, wr, a, sz, wd, rd, rf, rl, w);
    check($sformatf("d%0d rdata @%h sz%0d", d, a, sz), rd, exp_rd);
    check($sformatf("d%0d waits @%h", d, a), 32'(w), 32'(exp_w));
    check($sformatf("d%0d resp_last @%h", d, a), {31'h0, rl}, {31'h0, ERR_EN && !lg});
    check($sformatf("d%0d resp_first @%h", d, a), {31'h0, rf}, {31'h0, ERR_EN && !lg});
    if (wr && lg) ref_write(d, a, sz, wd);
  endtask

  // Watchdog: a hung handshake must still end the run
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd;
    logic [31:0] a;
    logic [2:0]  sz;
    logic        wr;

    for (int d = 0; d < 2; d++) begin
      bus_idle(d);
      rst[d] = 1'b1;
    end
    repeat (2) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      check($sformatf("d%0d reset hreadyout", d), {31'h0, hreadyout[d]}, 32'h1);
      check($sformatf("d%0d reset hresp", d), {31'h0, hresp[d]}, 32'h0);
      check($sformatf("d%0d reset hrdata", d), hrdata[d], 32'h0);
      rst[d] = 1'b0;
    end

    // Fill both memories so every later read has a defined expectation
    for (int d = 0; d < 2; d++)
      for (int i = 0; i < int'(DEPTH); i++)
        do_check(d, 1'b1, 32'(i * 4), 3'd2, $urandom, rd);

    // Word write then read, zero wait states
    do_check(0, 1'b1, 32'h10, 3'd2, 32'hDEADBEEF, rd);
    do_check(0, 1'b0, 32'h10, 3'd2, 32'h0, rd);
    check("deadbeef", rd, 32'hDEADBEEF);

    // Byte and halfword lane merging
    do_check(0, 1'b1, 32'h10, 3'd2, 32'h11223344, rd);
    do_check(0, 1'b1, 32'h13, 3'd0, 32'hAAAAAAAA, rd);
    do_check(0, 1'b0, 32'h10, 3'd2, 32'h0, rd);
    check("byte_merge", rd, 32'hAA223344);
    do_check(0, 1'b1, 32'h10, 3'd1, 32'h55665566, rd);
    do_check(0, 1'b0, 32'h10, 3'd2, 32'h0, rd);
    check("half_merge", rd, 32'hAA225566);

    // Two wait states on a read
    do_check(1, 1'b1, 32'h84, 3'd2, 32'hCAFEF00D, rd);
    do_check(1, 1'b0, 32'h84, 3'd2, 32'h0, rd);
    check("ws2_read", rd, 32'hCAFEF00D);

    // Back-to-back write then read of the same word, no bubble
    @(negedge clk);
    hsel[0] = 1'b1; haddr[0] = 32'h20; hwrite[0] = 1'b1; hsize[0] = 3'd2; htrans[0] = 2'b10;
    @(negedge clk);
    check("b2b write phase ready", {31'h0, hreadyout[0]}, 32'h1);
    check("b2b write phase rdata", hrdata[0], 32'h0);
    hwdata[0] = 32'h1; haddr[0] = 32'h20; hwrite[0] = 1'b0; htrans[0] = 2'b10;
    @(negedge clk);
    check("b2b read ready", {31'h0, hreadyout[0]}, 32'h1);
    check("b2b read data", hrdata[0], 32'h1);
    ref_write(0, 32'h20, 3'd2, 32'h1);
    bus_idle(0);

    // Out-of-range read and write
    do_check(0, 1'b0, 32'(NBYTE), 3'd2, 32'h0, rd);
    check("oor read data", rd, 32'h0);
    do_check(0, 1'b1, 32'(NBYTE), 3'd2, 32'h0BADBAD0, rd);
    do_check(0, 1'b0, 32'h0, 3'd2, 32'h0, rd);
    do_check(1, 1'b0, 32'(NBYTE + 4), 3'd2, 32'h0, rd);

    // Reset during the wait phase of a write abandons it
    @(negedge clk);
    hsel[1] = 1'b1; haddr[1] = 32'h40; hwrite[1] = 1'b1; hsize[1] = 3'd2; htrans[1] = 2'b10;
    @(negedge clk);
    check("rst_wait stalled", {31'h0, hreadyout[1]}, 32'h0);
    hsel[1] = 1'b0; htrans[1] = 2'b00; hwdata[1] = 32'h99999999; rst[1] = 1'b1;
    @(negedge clk);
    check("rst_wait hreadyout", {31'h0, hreadyout[1]}, 32'h1);
    check("rst_wait hresp", {31'h0, hresp[1]}, 32'h0);
    check("rst_wait hrdata", hrdata[1], 32'h0);
    rst[1] = 1'b0;
    bus_idle(1);
    do_check(1, 1'b0, 32'h40, 3'd2, 32'h0, rd);

    // Randomized single transfers, including illegal sizes, misalignment and out-of-range
    for (int d = 0; d < 2; d++) begin
      for (int n = 0; n < 200; n++) begin
        wr = 1'($urandom_range(0, 1));
        sz = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(3, 7)) : 3'($urandom_range(0, 2));
        if ($urandom_range(0, 9) == 0) a = 32'($urandom_range(NBYTE, 2 * NBYTE));
        else                           a = 32'($urandom_range(0, NBYTE - 1));
        if (sz <= 3'd2 && $urandom_range(0, 3) != 0) a = a & ~((32'h1 << sz) - 32'h1);
        do_check(d, wr, a, sz, $urandom, rd);
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
